readout_sequencer: RTL

READOUT_SEQUENCER -- requirements
Module: readout_sequencer

---
 rtl/readout_sequencer_if.sv | 36 +++
 rtl/readout_sequencer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_sequencer_if.sv
// rtl/readout_sequencer_if.sv - channel bus and output stream bundle for readout_sequencer
//
// Signals:
//   ch_trigger      [NCH]        trigger pulse to masked channels
//   ch_read_request [NCH]        one-hot read request to the selected channel
//   ch_rd_strobe                 current channel word consumed
//   ch_ro_enable    [NCH]        per-channel readout-enable
//   ch_rodone_n     [NCH]        per-channel readout done, active-low
//   ch_data         [NCH*WIDTH]  per-channel sample bus, channel i at [i*WIDTH +: WIDTH]
//   out_data/out_valid/out_ready output sample stream, valid-ready
// Modports: master = sequencer side, slave = channels plus stream sink.

interface readout_sequencer_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 12
);
    logic [NCH-1:0]       ch_trigger;
    logic [NCH-1:0]       ch_read_request;
    logic                 ch_rd_strobe;
    logic [NCH-1:0]       ch_ro_enable;
    logic [NCH-1:0]       ch_rodone_n;
    logic [NCH*WIDTH-1:0] ch_data;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output ch_trigger, ch_read_request, ch_rd_strobe, out_data, out_valid,
        input  ch_ro_enable, ch_rodone_n, ch_data, out_ready
    );

    modport slave (
        input  ch_trigger, ch_read_request, ch_rd_strobe, out_data, out_valid,
        output ch_ro_enable, ch_rodone_n, ch_data, out_ready
    );
endinterface

// File: rtl/readout_sequencer.sv
// rtl/readout_sequencer.sv - multi-channel digitizer frame readout sequencer
//
// Ports:
//   clk           system clock
//   reset_n       synchronous active-low reset
//   trigger_in    start one frame readout (honoured only when idle)
//   ch_mask       channels included in the frame, latched at frame start
//   words_per_ch  samples read per channel, latched at frame start
//   bus           readout_sequencer_if.master: channel handshake and output stream
//   busy          high whenever the sequencer is not idle
//   frame_done    one-cycle pulse at end of frame
//   timeout_err   sticky per-channel timeout flags, cleared at frame start
// Build option: CHANNEL_HEADER_EN emits a {4'hA, channel index} header word
// ahead of each channel's samples.

module readout_sequencer #(
    parameter int NCH   = 4,
    parameter int WIDTH = 12,
    parameter int SIZE  = 12
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 trigger_in,
    input  logic [NCH-1:0]       ch_mask,
    input  logic [SIZE-1:0]      words_per_ch,
    readout_sequencer_if.master  bus,
    output logic                 busy,
    output logic                 frame_done,
    output logic [NCH-1:0]       timeout_err
);
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        IDLE, ARM, WAIT_RO, READ, NEXT, DONE
    } state_t;

    state_t state, state_d;

    logic [NCH-1:0]   mask_q;
    logic [SIZE-1:0]  words_q;
    logic [SIZE-1:0]  cnt;
    logic [7:0]       tmo;
    logic [IDXW-1:0]  idx;
    logic [WIDTH-1:0] out_data_q;
    logic             out_valid_q;

    logic             can_load;
    logic             ld_word;
    logic             latch_cfg;
    logic             clr_cnt;
    logic             clr_tmo;
    logic             inc_tmo;
    logic             set_tmo_err;
    logic             sel_ld;
    logic [IDXW-1:0]  sel_d;
    logic [NCH-1:0]   trig_o;
    logic [NCH-1:0]   req_o;
    logic [IDXW:0]    first_ch;
    logic [IDXW:0]    next_ch;
    logic [SIZE:0]    cnt_inc;
    logic             ro_en_sel;
    logic             rodone_sel;

`ifdef CHANNEL_HEADER_EN
    logic             hdr_pend;
    logic             hdr_set;
    logic             ld_hdr;
    logic [WIDTH-1:0] hdr_word;
    assign hdr_word = {4'hA, (WIDTH-4)'(idx)};
`endif

    // Lowest set bit of m at position >= start; MSB of the result is the found flag.
    function automatic logic [IDXW:0] find_from(input logic [NCH-1:0] m, input int start);
        logic [IDXW:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (i >= start && m[i]) begin
                r = {1'b1, IDXW'(i)};
            end
        end
        return r;
    endfunction

    // A new word may enter the output register if it is empty or being drained this cycle.
    assign can_load   = !out_valid_q || bus.out_ready;
    assign cnt_inc    = {1'b0, cnt} + (SIZE+1)'(1);
    assign ro_en_sel  = bus.ch_ro_enable[idx];
    assign rodone_sel = bus.ch_rodone_n[idx];
    assign first_ch   = find_from(ch_mask, 0);
    assign next_ch    = find_from(mask_q, int'(idx) + 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        ld_word     = 1'b0;
        latch_cfg   = 1'b0;
        clr_cnt     = 1'b0;
        clr_tmo     = 1'b0;
        inc_tmo     = 1'b0;
        set_tmo_err = 1'b0;
        sel_ld      = 1'b0;
        sel_d       = idx;
        trig_o      = '0;
        req_o       = '0;
        frame_done  = 1'b0;
`ifdef CHANNEL_HEADER_EN
        hdr_set     = 1'b0;
        ld_hdr      = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (trigger_in) state_d = ARM;
            end
            ARM: begin
                trig_o    = ch_mask;
                latch_cfg = 1'b1;
                clr_cnt   = 1'b1;
                clr_tmo   = 1'b1;
                if (first_ch[IDXW] && words_per_ch != '0) begin
                    sel_ld  = 1'b1;
                    sel_d   = first_ch[IDXW-1:0];
                    state_d = WAIT_RO;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT_RO: begin
                req_o[idx] = 1'b1;
                if (ro_en_sel) begin
                    clr_tmo = 1'b1;
                    state_d = READ;
`ifdef CHANNEL_HEADER_EN
                    hdr_set = 1'b1;
`endif
                end else if (tmo == 8'hFF) begin
                    set_tmo_err = 1'b1;
                    state_d     = NEXT;
                end else begin
                    inc_tmo = 1'b1;
                end
            end
            READ: begin
                req_o[idx] = 1'b1;
`ifdef CHANNEL_HEADER_EN
                if (hdr_pend) begin
                    ld_hdr = can_load;
                end else
`endif
                begin
                    ld_word = ro_en_sel && can_load;
                    // Count-complete and short-channel done both land here, so
                    // coincident conditions still produce a single exit.
                    if ((ld_word && cnt_inc == {1'b0, words_q}) || !rodone_sel) begin
                        state_d = NEXT;
                    end
                end
            end
            NEXT: begin
                clr_cnt = 1'b1;
                clr_tmo = 1'b1;
                if (next_ch[IDXW]) begin
                    sel_ld  = 1'b1;
                    sel_d   = next_ch[IDXW-1:0];
                    state_d = WAIT_RO;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q      <= '0;
            words_q     <= '0;
            cnt         <= '0;
            tmo         <= '0;
            idx         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            timeout_err <= '0;
`ifdef CHANNEL_HEADER_EN
            hdr_pend    <= 1'b0;
`endif
        end else begin
            if (latch_cfg) begin
                mask_q      <= ch_mask;
                words_q     <= words_per_ch;
                timeout_err <= '0;
            end
            if (set_tmo_err) timeout_err[idx] <= 1'b1;
            if (sel_ld) idx <= sel_d;

            if (clr_cnt)      cnt <= '0;
            else if (ld_word) cnt <= cnt + SIZE'(1);

            if (clr_tmo)      tmo <= '0;
            else if (inc_tmo) tmo <= tmo + 8'd1;

            if (ld_word) begin
                out_data_q  <= bus.ch_data[int'(idx)*WIDTH +: WIDTH];
                out_valid_q <= 1'b1;
`ifdef CHANNEL_HEADER_EN
            end else if (ld_hdr) begin
                out_data_q  <= hdr_word;
                out_valid_q <= 1'b1;
`endif
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

`ifdef CHANNEL_HEADER_EN
            if (hdr_set)     hdr_pend <= 1'b1;
            else if (ld_hdr) hdr_pend <= 1'b0;
`endif
        end
    end

    assign busy                = (state != IDLE);
    assign bus.ch_trigger      = trig_o;
    assign bus.ch_read_request = req_o;
    assign bus.ch_rd_strobe    = ld_word;
    assign bus.out_data        = out_data_q;
    assign bus.out_valid       = out_valid_q;

endmodule
